// File: rtl/bit_adder_pkg.sv
// bit_adder shared definitions.
// Width limits and the default cell width.
package bit_adder_pkg;

    localparam int BA_WIDTH_DEF = 1;
    localparam int BA_WIDTH_MIN = 1;
    localparam int BA_WIDTH_MAX = 64;

    typedef struct packed {
        logic cout;
        logic sum;
    } fa_out_t;

    function automatic fa_out_t fa_eval(
        input logic a,
        input logic b,
        input logic c
    );
        fa_out_t r;
        r.sum  = a ^ b ^ c;
        r.cout = (a & b) | (a & c) | (b & c);
        return r;
    endfunction

endpackage

// File: rtl/bit_adder_if.sv
// Operand/result bundle for bit_adder.
// master drives operands, slave returns results.
interface bit_adder_if
    import bit_adder_pkg::*;
#(
    parameter int WIDTH = BA_WIDTH_DEF
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    modport master (
        output a, b, cin,
        input  sum, cout, sum_q, cout_q
    );

    modport slave (
        input  a, b, cin,
        output sum, cout, sum_q, cout_q
    );
endinterface

// File: rtl/full_adder_cell.sv
// Single-bit full adder cell, purely combinational.
// Replicated along the ripple carry chain in bit_adder.
module full_adder_cell
    import bit_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    fa_out_t r;

    always_comb begin
        r    = fa_eval(a, b, cin);
        sum  = r.sum;
        cout = r.cout;
    end
endmodule

// File: rtl/bit_adder.sv
// Ripple-carry adder with combinational and registered results.
// Registered copy is cleared asynchronously by rst_n.
module bit_adder
    import bit_adder_pkg::*;
#(
    parameter int WIDTH = BA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [WIDTH-1:0] sum_q,
    output logic             cout_q
);
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (s[i]),
            .cout (carry[i+1])
        );
    end

    assign sum  = s;
    assign cout = carry[WIDTH];

    always_comb begin
        sum_d  = s;
        cout_d = carry[WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end
endmodule

// File: tb/tb_bit_adder.sv
// Directed and random checks for bit_adder at WIDTH 1 and 8.
module tb_bit_adder;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    bit_adder_if #(.WIDTH(1)) if1 ();
    bit_adder_if #(.WIDTH(8)) if8 ();

    bit_adder #(.WIDTH(1)) u_w1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (if1.a),
        .b      (if1.b),
        .cin    (if1.cin),
        .sum    (if1.sum),
        .cout   (if1.cout),
        .sum_q  (if1.sum_q),
        .cout_q (if1.cout_q)
    );

    bit_adder #(.WIDTH(8)) u_w8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .a      (if8.a),
        .b      (if8.b),
        .cin    (if8.cin),
        .sum    (if8.sum),
        .cout   (if8.cout),
        .sum_q  (if8.sum_q),
        .cout_q (if8.cout_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set1(input logic a, input logic b, input logic c);
        if1.a   = a;
        if1.b   = b;
        if1.cin = c;
    endtask

    task automatic set8(input logic [7:0] a, input logic [7:0] b,
                        input logic c);
        if8.a   = a;
        if8.b   = b;
        if8.cin = c;
    endtask

    logic [1:0] tt_exp [8];
    logic [8:0] exp9;
    logic [8:0] prev9;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rc;

    initial begin
        total = 0;
        bad   = 0;
        // {cout,sum} for abc = 000..111
        tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10,
                   2'b01, 2'b10, 2'b10, 2'b11};
        rst_n = 1'b0;
        set1(0, 0, 0);
        set8(8'h00, 8'h00, 1'b0);
        #1;
        chk("rst_sum_q_w1", 64'(if1.sum_q), 64'h0);
        chk("rst_cout_q_w1", 64'(if1.cout_q), 64'h0);
        chk("rst_sum_q_w8", 64'(if8.sum_q), 64'h0);
        chk("rst_cout_q_w8", 64'(if8.cout_q), 64'h0);
        chk("w8_zero", 64'({if8.cout, if8.sum}), 64'h000);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            set1(v[2], v[1], v[0]);
            #1;
            chk($sformatf("tt_%0d", i), 64'({if1.cout, if1.sum}),
                64'(tt_exp[i]));
        end

        @(negedge clk);
        rst_n = 1'b1;
        set1(1, 0, 0);
        @(posedge clk);
        #1;
        chk("pre_sum_q", 64'(if1.sum_q), 64'h1);
        chk("pre_cout_q", 64'(if1.cout_q), 64'h0);

        @(negedge clk);
        set1(1, 1, 0);
        #1;
        chk("hold_sum_q", 64'(if1.sum_q), 64'h1);
        chk("hold_cout_q", 64'(if1.cout_q), 64'h0);
        @(posedge clk);
        #1;
        chk("lat_sum_q", 64'(if1.sum_q), 64'h0);
        chk("lat_cout_q", 64'(if1.cout_q), 64'h1);

        @(negedge clk);
        set1(1, 0, 0);
        @(posedge clk);
        #1;
        chk("set_sum_q", 64'(if1.sum_q), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sum_q", 64'(if1.sum_q), 64'h0);
        chk("arst_cout_q", 64'(if1.cout_q), 64'h0);
        chk("arst_sum", 64'(if1.sum), 64'h1);
        chk("arst_cout", 64'(if1.cout), 64'h0);
        @(posedge clk);
        #1;
        chk("arst_hold_sum_q", 64'(if1.sum_q), 64'h0);

        @(negedge clk);
        rst_n = 1'b1;
        set1(1, 0, 1);
        #1;
        chk("rel_sum_q", 64'(if1.sum_q), 64'h0);
        chk("rel_cout_q", 64'(if1.cout_q), 64'h0);
        @(posedge clk);
        #1;
        chk("rel_cap_sum_q", 64'(if1.sum_q), 64'h0);
        chk("rel_cap_cout_q", 64'(if1.cout_q), 64'h1);

        set8(8'hFF, 8'h01, 1'b0);
        #1;
        chk("w8_ff_01", 64'({if8.cout, if8.sum}), 64'h100);
        set8(8'h5A, 8'hA5, 1'b1);
        #1;
        chk("w8_5a_a5", 64'({if8.cout, if8.sum}), 64'h100);
        set8(8'h12, 8'h34, 1'b0);
        #1;
        chk("w8_12_34", 64'({if8.cout, if8.sum}), 64'h046);
        set8(8'hFF, 8'hFF, 1'b1);
        #1;
        chk("w8_allone", 64'({if8.cout, if8.sum}), 64'h1FF);
        set8(8'hFF, 8'h00, 1'b1);
        #1;
        chk("w8_wrap", 64'({if8.cout, if8.sum}), 64'h100);

        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            set8(ra, rb, rc);
            exp9 = 9'(ra) + 9'(rb) + 9'(rc);
            #1;
            chk("rnd_comb", 64'({if8.cout, if8.sum}), 64'(exp9));
            prev9 = exp9;
            @(posedge clk);
            #1;
            chk("rnd_reg", 64'({if8.cout_q, if8.sum_q}), 64'(prev9));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
